// File: rtl/mm2s_cntrl_parser_if.sv
// MM2S control-stream and descriptor bundle for the control-word parser.
// The slave modport is the parser's view; the master modport is the stream source / AES sink.
interface mm2s_cntrl_parser_if #(
    parameter int TDATA_W = 32
);
    logic [TDATA_W-1:0]   m_axis_mm2s_cntrl_tdata;
    logic [TDATA_W/8-1:0] m_axis_mm2s_cntrl_tkeep;
    logic                 m_axis_mm2s_cntrl_tvalid;
    logic                 m_axis_mm2s_cntrl_tlast;
    logic                 m_axis_mm2s_cntrl_tready;
    logic                 desc_valid;
    logic                 desc_ready;
    logic [TDATA_W-1:0]   desc_flag;
    logic [5*TDATA_W-1:0] desc_app;
    logic                 cntrl_err;
    logic [7:0]           err_cnt;

    modport slave (
        input  m_axis_mm2s_cntrl_tdata, m_axis_mm2s_cntrl_tkeep, m_axis_mm2s_cntrl_tvalid,
        input  m_axis_mm2s_cntrl_tlast, desc_ready,
        output m_axis_mm2s_cntrl_tready, desc_valid, desc_flag, desc_app, cntrl_err, err_cnt
    );

    modport master (
        output m_axis_mm2s_cntrl_tdata, m_axis_mm2s_cntrl_tkeep, m_axis_mm2s_cntrl_tvalid,
        output m_axis_mm2s_cntrl_tlast, desc_ready,
        input  m_axis_mm2s_cntrl_tready, desc_valid, desc_flag, desc_app, cntrl_err, err_cnt
    );
endinterface

// File: rtl/mm2s_cntrl_parser.sv
// Parses 6-word MM2S control frames (flag, app0..app4) into a held descriptor for the AES datapath.
// Optional macro MM2S_CNTRL_FLAG_CHECK_EN: word 0 must carry 4'hA in its top nibble.
module mm2s_cntrl_parser #(
    parameter int C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH = 32
) (
    input  logic                     m_axi_mm2s_aclk,
    input  logic                     mm2s_cntrl_reset_out_n,
    mm2s_cntrl_parser_if.slave       bus
);
    localparam int W = C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH;

    typedef enum logic [1:0] {IDLE, APP, DRAIN, HOLD} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       beat;
    logic       tlast;
    logic       flag_ok;
    logic       err_now;
    logic       unused_tkeep;

    assign beat         = bus.m_axis_mm2s_cntrl_tvalid && bus.m_axis_mm2s_cntrl_tready;
    assign tlast        = bus.m_axis_mm2s_cntrl_tlast;
    assign unused_tkeep = ^bus.m_axis_mm2s_cntrl_tkeep;

`ifdef MM2S_CNTRL_FLAG_CHECK_EN
    assign flag_ok = (bus.m_axis_mm2s_cntrl_tdata[W-1 -: 4] == 4'hA);
`else
    assign flag_ok = 1'b1;
`endif

    // Any tlast that does not land on the 6th word ends a malformed frame.
    always_comb begin
        err_now = 1'b0;
        if (beat && tlast)
            err_now = (state == IDLE) || (state == DRAIN) || (state == APP && cnt != 3'd5);
    end

    always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_cntrl_reset_out_n) begin
        if (!mm2s_cntrl_reset_out_n) begin
            state                    <= IDLE;
            cnt                      <= '0;
            bus.m_axis_mm2s_cntrl_tready <= 1'b0;
            bus.desc_valid           <= 1'b0;
            bus.desc_flag            <= '0;
            bus.desc_app             <= '0;
            bus.cntrl_err            <= 1'b0;
            bus.err_cnt              <= '0;
        end else begin
            bus.cntrl_err <= err_now;
            if (err_now && bus.err_cnt != 8'hFF)
                bus.err_cnt <= bus.err_cnt + 8'd1;

            case (state)
                IDLE: begin
                    bus.m_axis_mm2s_cntrl_tready <= 1'b1;
                    if (beat && !tlast) begin
                        if (flag_ok) begin
                            bus.desc_flag <= bus.m_axis_mm2s_cntrl_tdata;
                            cnt           <= 3'd1;
                            state         <= APP;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                APP: begin
                    if (beat) begin
                        for (int i = 0; i < 5; i++)
                            if (cnt == 3'(i + 1))
                                bus.desc_app[W*i +: W] <= bus.m_axis_mm2s_cntrl_tdata;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd5) begin
                            if (tlast) begin
                                state                        <= HOLD;
                                bus.desc_valid               <= 1'b1;
                                bus.m_axis_mm2s_cntrl_tready <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end else if (tlast) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (beat && tlast) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (bus.desc_ready) begin
                        state                        <= IDLE;
                        cnt                          <= '0;
                        bus.desc_valid               <= 1'b0;
                        bus.m_axis_mm2s_cntrl_tready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mm2s_cntrl_parser.sv
// Table-driven frame vectors with a descriptor scoreboard, plus hold, reset and saturation sequences.
module tb_mm2s_cntrl_parser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm2s_cntrl_parser_if #(.TDATA_W(32)) bus();

    mm2s_cntrl_parser #(.C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH(32)) dut (
        .m_axi_mm2s_aclk        (clk),
        .mm2s_cntrl_reset_out_n (rst_n),
        .bus                    (bus)
    );

    typedef struct packed {
        logic [31:0]  flag;
        logic [159:0] app;
    } desc_t;

    typedef struct {
        int          nb;
        int          last_at;
        logic [31:0] flag;
        logic [31:0] base;
        bit          good;
    } vec_t;

    int    tests = 0;
    int    failed = 0;
    int    vcycles = 0;
    int    obs_err = 0;
    int    exp_errs = 0;
    desc_t sb[$];

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic desc_t mk_desc(input logic [31:0] flag, input logic [31:0] base);
        desc_t d;
        d.flag = flag;
        for (int i = 0; i < 5; i++) d.app[32*i +: 32] = base + 32'(i);
        return d;
    endfunction

    // Monitor: pop the scoreboard on each descriptor handshake.
    always @(negedge clk) begin
        desc_t e;
        if (bus.desc_valid) vcycles++;
        if (bus.cntrl_err) obs_err++;
        if (bus.desc_valid && bus.desc_ready) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_desc: got flag %h expected no descriptor", bus.desc_flag);
            end else begin
                e = sb.pop_front();
                check("desc_flag", 160'(bus.desc_flag), 160'(e.flag));
                check("desc_app", bus.desc_app, e.app);
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l);
        int guard = 0;
        @(negedge clk);
        bus.m_axis_mm2s_cntrl_tdata  = d;
        bus.m_axis_mm2s_cntrl_tkeep  = 4'($urandom);
        bus.m_axis_mm2s_cntrl_tvalid = 1'b1;
        bus.m_axis_mm2s_cntrl_tlast  = l;
        while (!bus.m_axis_mm2s_cntrl_tready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.m_axis_mm2s_cntrl_tready) begin
            tests++;
            failed++;
            $display("FAIL tready_timeout: got tready 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input int nb, input int last_at, input logic [31:0] flag,
                              input logic [31:0] base);
        for (int b = 1; b <= nb; b++)
            send_beat((b == 1) ? flag : base + 32'(b - 2), b == last_at);
        @(negedge clk);
        bus.m_axis_mm2s_cntrl_tvalid = 1'b0;
        bus.m_axis_mm2s_cntrl_tlast  = 1'b0;
    endtask

    function automatic void note_err();
        exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
    endfunction

    initial begin
        vec_t  vecs[9];
        desc_t e;
        int    e0, v0;

        vecs[0] = '{6, 6, 32'hA000_0000, 32'h1,         1'b1};
        vecs[1] = '{4, 4, 32'hA000_0000, 32'h100,       1'b0};
        vecs[2] = '{6, 6, 32'hA000_0001, 32'h10,        1'b1};
        vecs[3] = '{8, 8, 32'hA000_0002, 32'h200,       1'b0};
        vecs[4] = '{1, 1, 32'hA000_0003, 32'h300,       1'b0};
        vecs[5] = '{2, 2, 32'hA000_0004, 32'h400,       1'b0};
        vecs[6] = '{7, 7, 32'hA000_0005, 32'h500,       1'b0};
`ifdef MM2S_CNTRL_FLAG_CHECK_EN
        vecs[7] = '{6, 6, 32'h5000_0000, 32'h600,       1'b0};
`else
        vecs[7] = '{6, 6, 32'h5000_0000, 32'h600,       1'b1};
`endif
        vecs[8] = '{6, 6, 32'hAFED_CAFE, 32'hDEAD_0000, 1'b1};

        bus.m_axis_mm2s_cntrl_tdata  = '0;
        bus.m_axis_mm2s_cntrl_tkeep  = '0;
        bus.m_axis_mm2s_cntrl_tvalid = 1'b0;
        bus.m_axis_mm2s_cntrl_tlast  = 1'b0;
        bus.desc_ready               = 1'b1;

        #1;
        check("rst_tready", 160'(bus.m_axis_mm2s_cntrl_tready), 160'(0));
        check("rst_desc_valid", 160'(bus.desc_valid), 160'(0));
        check("rst_desc_flag", 160'(bus.desc_flag), 160'(0));
        check("rst_desc_app", bus.desc_app, 160'(0));
        check("rst_cntrl_err", 160'(bus.cntrl_err), 160'(0));
        check("rst_err_cnt", 160'(bus.err_cnt), 160'(0));

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_rst", 160'(bus.m_axis_mm2s_cntrl_tready), 160'(1));

        for (int v = 0; v < 9; v++) begin
            e0 = obs_err;
            v0 = vcycles;
            if (vecs[v].good) sb.push_back(mk_desc(vecs[v].flag, vecs[v].base));
            else note_err();
            send_frame(vecs[v].nb, vecs[v].last_at, vecs[v].flag, vecs[v].base);
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_err_cnt", v), 160'(bus.err_cnt), 160'(exp_errs));
            check($sformatf("v%0d_err_pulses", v), 160'(obs_err - e0), 160'(vecs[v].good ? 0 : 1));
            check($sformatf("v%0d_valid_cycles", v), 160'(vcycles - v0), 160'(vecs[v].good ? 1 : 0));
            check($sformatf("v%0d_sb_empty", v), 160'(sb.size()), 160'(0));
        end

        // Back-pressure: descriptor held with desc_ready low for 10 cycles.
        bus.desc_ready = 1'b0;
        sb.push_back(mk_desc(32'hA000_0000, 32'h1));
        send_frame(6, 6, 32'hA000_0000, 32'h1);
        check("hold_latency_valid", 160'(bus.desc_valid), 160'(1));
        check("hold_tready", 160'(bus.m_axis_mm2s_cntrl_tready), 160'(0));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_valid", 160'(bus.desc_valid), 160'(1));
            check("hold_tready_low", 160'(bus.m_axis_mm2s_cntrl_tready), 160'(0));
            check("hold_flag", 160'(bus.desc_flag), 160'(32'hA000_0000));
            check("hold_app", bus.desc_app, 160'h00000005_00000004_00000003_00000002_00000001);
        end
        @(posedge clk);
        #1 bus.desc_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_tready", 160'(bus.m_axis_mm2s_cntrl_tready), 160'(1));
        check("release_valid", 160'(bus.desc_valid), 160'(0));
        check("release_sb_empty", 160'(sb.size()), 160'(0));

        // Reset in the middle of a frame discards it without counting an error.
        for (int b = 0; b < 3; b++) send_beat((b == 0) ? 32'hA111_1111 : 32'(b), 1'b0);
        @(negedge clk);
        bus.m_axis_mm2s_cntrl_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_tready", 160'(bus.m_axis_mm2s_cntrl_tready), 160'(0));
        check("midrst_err_cnt", 160'(bus.err_cnt), 160'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_errs = 0;
        @(negedge clk);
        check("midrst_tready_up", 160'(bus.m_axis_mm2s_cntrl_tready), 160'(1));
        e0 = obs_err;
        sb.push_back(mk_desc(32'hA222_2222, 32'h7000));
        send_frame(6, 6, 32'hA222_2222, 32'h7000);
        repeat (4) @(negedge clk);
        check("postrst_err_cnt", 160'(bus.err_cnt), 160'(0));
        check("postrst_err_pulses", 160'(obs_err - e0), 160'(0));
        check("postrst_sb_empty", 160'(sb.size()), 160'(0));

        // Saturation of the error counter.
        for (int f = 0; f < 255; f++) begin
            send_frame(1, 1, 32'hA000_0000, 32'h0);
            note_err();
        end
        repeat (3) @(negedge clk);
        check("sat_255", 160'(bus.err_cnt), 160'(exp_errs));
        send_frame(1, 1, 32'hA000_0000, 32'h0);
        note_err();
        repeat (3) @(negedge clk);
        check("sat_256", 160'(bus.err_cnt), 160'(8'hFF));
        check("sat_model", 160'(bus.err_cnt), 160'(exp_errs));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end
endmodule
